// File: rtl/bit4_accum_top_if.sv
// -----------------------------------------------------------------------------
// bit4_accum_top_if
// Handshake bundle for the 4-bit packet accumulator.
//   Operand side : in_valid, in_ready, in_a[3:0], in_last
//   Result side  : out_valid, out_ready, out_sum[3:0], out_ovf, out_cnt[CNT_W-1:0]
// Modports:
//   slave  - the accumulator (consumes operands, produces results)
//   master - the environment (produces operands, consumes results)
// -----------------------------------------------------------------------------
interface bit4_accum_top_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_a;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_cnt;

  modport slave (
    input  in_valid, in_a, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_cnt
  );

  modport master (
    output in_valid, in_a, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_cnt
  );
endinterface

// File: rtl/bit4_accum_top.sv
// -----------------------------------------------------------------------------
// bit4_accum_top
// Accumulates a packet of unsigned 4-bit operands through a ripple-carry adder,
// tracking a sticky carry-out flag and a saturating beat counter, then holds
// the packet result until the consumer takes it.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - bit4_accum_top_if.slave (operand and result handshakes)
//
// Parameter:
//   CNT_W  - width of the beat counter out_cnt (must match the interface)
//
// Build option:
//   BIT4_ACCUM_SATURATE_EN - when defined, the accumulator clamps to 4'hF on a
//   carry-out; otherwise it wraps modulo 16. out_ovf/out_cnt are the same in
//   both builds.
// -----------------------------------------------------------------------------
module bit4_accum_top #(
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  bit4_accum_top_if.slave bus
);

`ifdef BIT4_ACCUM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       add_res;

  // 4-bit ripple-carry full-adder chain, carry-in 0. Returns {carry_out, sum}.
  function automatic logic [4:0] rca4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[4], s};
  endfunction

  // Once a carry is seen in the saturating build the accumulator pins at F;
  // any later nonzero add carries again, so it stays F for the packet.
  function automatic logic [3:0] fold_sum(input logic [3:0] s, input logic carry,
                                          input bit sat_en);
    return (sat_en && carry) ? 4'hF : s;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    add_res = rca4(acc_q, bus.in_a);
    case (state_q)
      ACC: begin
        if (bus.in_valid) begin
          acc_d = fold_sum(add_res[3:0], add_res[4], SAT_EN);
          ovf_d = ovf_q | add_res[4];
          cnt_d = cnt_inc(cnt_q);
          if (bus.in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        // Result leaves on this edge; operands are accepted from next cycle.
        if (bus.out_ready) begin
          acc_d   = 4'h0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= 4'h0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags come from the state register alone.
  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_cnt   = cnt_q;

endmodule

// File: tb/tb_bit4_accum_top.sv
module tb_bit4_accum_top;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit4_accum_top_if #(.CNT_W(4)) bus ();
  bit4_accum_top_if #(.CNT_W(2)) bus2 ();

  bit4_accum_top #(.CNT_W(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  bit4_accum_top #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

`ifdef BIT4_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: running total and beat count; the result is derived
  // arithmetically from the total when the last beat arrives.
  int m_total, m_n;
  bit m_hold;
  int e_sum, e_ovf, e_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_total = 0; m_n = 0;
    end else if (!m_hold) begin
      if (bus.in_valid) begin
        m_total = m_total + int'(bus.in_a);
        m_n = m_n + 1;
        if (bus.in_last) begin
          m_hold = 1;
          e_ovf  = (m_total >= 16) ? 1 : 0;
          e_sum  = SAT ? ((m_total > 15) ? 15 : m_total) : (m_total % 16);
          e_cnt  = (m_n > 15) ? 15 : m_n;
        end
      end
    end else if (bus.out_ready) begin
      m_hold = 0; m_total = 0; m_n = 0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", int'(bus.in_ready), m_hold ? 0 : 1);
    chk("out_valid", int'(bus.out_valid), m_hold ? 1 : 0);
    if (m_hold) begin
      chk("out_sum", int'(bus.out_sum), e_sum);
      chk("out_ovf", int'(bus.out_ovf), e_ovf);
      chk("out_cnt", int'(bus.out_cnt), e_cnt);
    end else if (!rst_n) begin
      chk("rst_sum", int'(bus.out_sum), 0);
      chk("rst_ovf", int'(bus.out_ovf), 0);
      chk("rst_cnt", int'(bus.out_cnt), 0);
    end
  end

  task automatic beat(input logic [3:0] a, input logic last);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_last = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_a = 4'h0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("take_in_ready", int'(bus.in_ready), 1);
    chk("take_out_valid", int'(bus.out_valid), 0);
  endtask

  task automatic pin(input string name, input int s, input int o, input int c);
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_sum"}, int'(bus.out_sum), s);
    chk({name, "_ovf"}, int'(bus.out_ovf), o);
    chk({name, "_cnt"}, int'(bus.out_cnt), c);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 0; bus.in_a = 0; bus.in_last = 0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_a = 0; bus2.in_last = 0; bus2.out_ready = 0;
    #1;
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_sum", int'(bus.out_sum), 0);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // 3,4,5(last): result one cycle after the last beat
    beat(4'd3, 0); beat(4'd4, 0); beat(4'd5, 1);
    pin("p345", 12, 0, 3);
    take();

    // 9,9(last): carry out of bit 3
    beat(4'd9, 0); beat(4'd9, 1);
    pin("p99", SAT ? 15 : 2, 1, 2);
    take();

    // 7(last), then hold with in_valid asserted for 5 cycles
    beat(4'd7, 1);
    bus.in_valid = 1; bus.in_a = 4'd5; bus.in_last = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      pin("hold7", 7, 0, 1);
      chk("hold7_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 0; bus.in_last = 0; bus.in_a = 0;
    take();
    chk("after_take_acc", int'(bus.out_sum), 0);
    chk("after_take_cnt", int'(bus.out_cnt), 0);

    // out_ready in ACC has no effect; back-to-back packets
    bus.out_ready = 1;
    @(posedge clk); #1;
    beat(4'd1, 0);
    bus.out_ready = 0;
    beat(4'd2, 1);
    pin("p12", 3, 0, 2);
    take();
    beat(4'd15, 1);
    pin("p15", 15, 0, 1);
    take();

    // 8,8 then reset mid-packet, then 1(last)
    beat(4'd8, 0); beat(4'd8, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sum", int'(bus.out_sum), 0);
    chk("midrst_ovf", int'(bus.out_ovf), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cnt", int'(bus.out_cnt), 0);
    beat(4'd1, 1);
    pin("p1", 1, 0, 1);
    take();

    // Reset while holding discards the result
    beat(4'd6, 1);
    pin("p6", 6, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("holdrst_valid", int'(bus.out_valid), 0);
    chk("holdrst_sum", int'(bus.out_sum), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero beats counted, no overflow
    beat(4'd0, 0); beat(4'd0, 1);
    pin("p00", 0, 0, 2);
    take();

    // Sticky overflow then small adds: 15,1,1 -> total 17
    beat(4'd15, 0); beat(4'd1, 0); beat(4'd1, 1);
    pin("p15_1_1", SAT ? 15 : 1, 1, 3);
    take();

    // Counter saturation: 16 beats of 1, total 16
    for (int i = 0; i < 16; i++) beat(4'd1, (i == 15) ? 1'b1 : 1'b0);
    pin("p16x1", SAT ? 15 : 0, 1, 15);
    take();

    // CNT_W=2: five zero beats, last on the fifth
    for (int i = 0; i < 5; i++) begin
      bus2.in_valid = 1; bus2.in_a = 0; bus2.in_last = (i == 4) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    bus2.in_valid = 0; bus2.in_last = 0;
    chk("w2_valid", int'(bus2.out_valid), 1);
    chk("w2_cnt", int'(bus2.out_cnt), 3);
    chk("w2_sum", int'(bus2.out_sum), 0);
    chk("w2_ovf", int'(bus2.out_ovf), 0);
    bus2.out_ready = 1;
    @(posedge clk); #1;
    bus2.out_ready = 0;
    chk("w2_take_in_ready", int'(bus2.in_ready), 1);
    chk("w2_take_cnt", int'(bus2.out_cnt), 0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bit4_accum_top.md
BIT4_ACCUM_TOP -- requirements
Module: bit4_accum_top

Interface
REQ-001 Parameter: CNT_W, default 4, width of beat counter output out_cnt.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  operand beat present.
REQ-005 in_ready  output  1  block accepts operand this cycle.
REQ-006 in_a  input  4  unsigned operand to add into accumulator.
REQ-007 in_last  input  1  marks final beat of a packet; sampled only with an accepted beat.
REQ-008 out_valid  output  1  packet result held and valid.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 out_sum  output  4  accumulated 4-bit sum of the packet.
REQ-011 out_ovf  output  1  sticky: a carry-out of bit 3 occurred during the packet.
REQ-012 out_cnt  output  CNT_W  number of beats accepted in the packet.

Function
REQ-013 Beat accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-014 Accumulation uses the 4-bit ripple-carry full-adder chain, with accumulator as A, in_a as B, and carry-in 0.
REQ-015 FSM has two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 ACC, accepted beat: acc <= acc + in_a mod 16; ovf <= ovf | carry-out; cnt <= cnt+1, saturating at 2^CNT_W-1.
REQ-017 ACC, accepted beat with in_last=1: state -> HOLD next cycle, with the updated acc/ovf/cnt visible.
REQ-018 Latency: result visible on out_* exactly one cycle after the in_last beat is accepted.
REQ-019 ACC, in_valid=0: hold all state.
REQ-020 HOLD: out_sum/out_ovf/out_cnt stable until out_ready=1; in_valid is ignored and no beat is accepted.
REQ-021 HOLD, out_ready=1: acc, ovf and cnt clear to 0; state -> ACC; in_ready=1 next cycle, not same-cycle.
REQ-022 out_ready while in ACC has no effect.
REQ-023 Single-beat packet (first beat has in_last=1): result = that operand, cnt=1.
REQ-024 Zero operands are counted as beats and never set ovf.
REQ-025 Outputs are registered; no combinational path from in_* to out_*.
REQ-026 in_ready and out_valid are decoded from state only.

Reset
REQ-027 rst_n=0 forces state ACC, acc=0, ovf=0, cnt=0 immediately, independent of clk.
REQ-028 During reset: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_cnt=0.
REQ-029 Reset mid-packet or in HOLD discards the partial or held result; no beat is accepted on the first edge after rst_n deasserts unless in_valid=1 at that edge.

Configuration
REQ-030 Macro BIT4_ACCUM_SATURATE_EN selects the overflow behaviour.
REQ-031 When defined: on carry-out, acc clamps to 4'hF and stays 4'hF for the rest of the packet.
REQ-032 Not defined: acc wraps modulo 16.
REQ-033 out_ovf and out_cnt behaviour is identical in both builds.

Verification
REQ-034 Reset, then beats 3, 4, 5(last) -> out_valid=1 next cycle; sum=12, ovf=0, cnt=3.
REQ-035 Beats 9, 9(last) -> without macro: sum=2, ovf=1; with macro: sum=15, ovf=1; cnt=2.
REQ-036 Packet 7(last), out_ready held 0 for 5 cycles with in_valid=1 -> result held at 7, in_ready=0, no beat absorbed; out_ready=1 -> in_ready=1 next cycle, acc=0.
REQ-037 Back-to-back packets [1,2(last)] and [15(last)] -> results 3/cnt=2, then 15/cnt=1, ovf=0 on both.
REQ-038 Beats 8, 8 followed by rst_n pulse, then 1(last) -> sum=1, ovf=0, cnt=1.
REQ-039 CNT_W=2, 5 zero beats, last on fifth -> cnt=3 (saturated), sum=0, ovf=0.
